// File: rtl/if_fetch_queue_if.sv
// Decode-side handshake bundle for the instruction fetch queue.
//
// Ports (signals):
//   id_valid_o  head entry of the fetch queue is valid
//   id_ready_i  decode accepts the head entry this cycle
//   id_pc_o     PC of the head entry
//   id_inst_o   instruction word of the head entry
//
// Handshake: a transfer happens on a rising clock edge where id_valid_o and
// id_ready_i are both high. While id_valid_o is high and id_ready_i is low the
// head (id_pc_o, id_inst_o) is held stable. id_ready_i is ignored while
// id_valid_o is low, and id_pc_o/id_inst_o read as zero in that case.
interface if_fetch_queue_if;
   logic        id_valid_o;
   logic        id_ready_i;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;

   modport master (
      output id_valid_o,
      output id_pc_o,
      output id_inst_o,
      input  id_ready_i
   );

   modport slave (
      input  id_valid_o,
      input  id_pc_o,
      input  id_inst_o,
      output id_ready_i
   );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: owns the PC, drives the instruction ROM and buffers
// fetched {pc, inst} pairs in a small FIFO whose head is offered to decode.
// Flush or branch redirect empties the FIFO and reloads the PC.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   rom_ce_o     ROM chip enable (registered, low during reset)
//   rom_addr_o   ROM byte address, always the current PC
//   rom_inst_i   ROM word, combinational from rom_addr_o
//   id           decode handshake (if_fetch_queue_if.master)
//   flush_i      flush request, target flush_pc_i (wins over branch)
//   flush_pc_i   flush target PC
//   branch_i     taken branch, target branch_pc_i
//   branch_pc_i  branch target PC
module if_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic                clk,
   input  logic                rst,
   output logic                rom_ce_o,
   output logic [31:0]         rom_addr_o,
   input  logic [31:0]         rom_inst_i,
   if_fetch_queue_if.master    id,
   input  logic                flush_i,
   input  logic [31:0]         flush_pc_i,
   input  logic                branch_i,
   input  logic [31:0]         branch_pc_i
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   r_pc;
   logic          r_ce;
   logic [31:0]   r_pc_q   [QDEPTH];
   logic [31:0]   r_inst_q [QDEPTH];
   logic [PW-1:0] r_wp;
   logic [PW-1:0] r_rp;
   logic [CW-1:0] r_cnt;

   logic          w_valid;
   logic          w_pop;
   logic          w_redirect;
   logic [31:0]   w_target;
   logic          w_fetch;

   assign w_valid    = (r_cnt != '0);
   assign w_pop      = w_valid && id.id_ready_i;
   assign w_redirect = flush_i || branch_i;
   assign w_target   = flush_i ? flush_pc_i : branch_pc_i;
   // A full queue may still fetch when the head leaves in the same cycle.
   assign w_fetch    = r_ce && !w_redirect && ((r_cnt < CW'(QDEPTH)) || w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc  <= RESET_PC;
         r_ce  <= 1'b0;
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         r_ce <= 1'b1;
         if (w_redirect) begin
            // Redirect drops everything queued, including a head that decode
            // is accepting this cycle; the target is forced word-aligned.
            r_pc  <= {w_target[31:2], 2'b00};
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
         end else begin
            if (w_fetch) begin
               r_pc <= r_pc + 32'd4;
               r_wp <= r_wp + PW'(1);
            end
            if (w_pop) begin
               r_rp <= r_rp + PW'(1);
            end
            case ({w_fetch, w_pop})
               2'b10:   r_cnt <= r_cnt + CW'(1);
               2'b01:   r_cnt <= r_cnt - CW'(1);
               default: r_cnt <= r_cnt;
            endcase
         end
      end
   end

   // Storage needs no reset: entries are only visible while counted valid.
   always_ff @(posedge clk) begin
      if (!rst && w_fetch) begin
         r_pc_q[r_wp]   <= r_pc;
         r_inst_q[r_wp] <= rom_inst_i;
      end
   end

   assign rom_ce_o     = r_ce;
   assign rom_addr_o   = r_pc;
   assign id.id_valid_o = w_valid;
   // Empty queue presents a zero NOP so stale slots never leak out.
   assign id.id_pc_o   = w_valid ? r_pc_q[r_rp]   : 32'h0;
   assign id.id_inst_o = w_valid ? r_inst_q[r_rp] : 32'h0;

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch;
  logic [31:0] branch_pc;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];

  if_fetch_queue_if id_bus();

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  if_fetch_queue #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_ce_o    (rom_ce),
    .rom_addr_o  (rom_addr),
    .rom_inst_i  (rom_inst),
    .id          (id_bus),
    .flush_i     (flush),
    .flush_pc_i  (flush_pc),
    .branch_i    (branch),
    .branch_pc_i (branch_pc)
  );

  // ROM content model: every word is a distinct function of its address.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign rom_inst = rom_ce ? rom_word(rom_addr) : 32'h0;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back({pc, rom_word(pc)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("rst_valid", {31'b0, id_bus.id_valid_o}, 32'h0);
    check("rst_ce",    {31'b0, rom_ce}, 32'h0);
    check("rst_addr",  rom_addr, 32'h0);
    check("rst_pc",    id_bus.id_pc_o, 32'h0);
    check("rst_inst",  id_bus.id_inst_o, 32'h0);
    rst = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (id_bus.id_valid_o && id_bus.id_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop_pc", id_bus.id_pc_o, 32'hDEAD_BEEF);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("pop_pc",   id_bus.id_pc_o,   e[63:32]);
          check("pop_inst", id_bus.id_inst_o, e[31:0]);
        end
      end else if (!id_bus.id_valid_o) begin
        check("nop_pc",   id_bus.id_pc_o,   32'h0);
        check("nop_inst", id_bus.id_inst_o, 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    flush_pc  = 32'h0;
    branch    = 1'b0;
    branch_pc = 32'h0;
    id_bus.id_ready_i = 1'b1;

    // Reset release with decode always ready: 0,4,8,C,10 one per cycle.
    expect_pc(32'h0);  expect_pc(32'h4);  expect_pc(32'h8);
    expect_pc(32'hC);  expect_pc(32'h10);
    do_reset();
    check("ce_first_cycle", {31'b0, rom_ce}, 32'h0);
    tick();
    check("ce_rises", {31'b0, rom_ce}, 32'h1);
    check("addr_first_fetch", rom_addr, 32'h0);
    repeat (6) tick();
    id_bus.id_ready_i = 1'b0;
    check("p1_drained", exp_q.size(), 32'd0);

    // Backpressure from release: fills to 2, pc holds at 8, head pc 0.
    do_reset();
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'b0, id_bus.id_valid_o}, 32'h1);
      check("bp_head_pc", id_bus.id_pc_o, 32'h0);
      check("bp_head_inst", id_bus.id_inst_o, rom_word(32'h0));
      check("bp_pc_hold", rom_addr, 32'h8);
      tick();
    end
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    id_bus.id_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_no_gap", {31'b0, id_bus.id_valid_o}, 32'h1);
      tick();
    end
    id_bus.id_ready_i = 1'b0;
    check("p2_drained", exp_q.size(), 32'd0);

    // Branch to 0x40 while full (head 0x10 is discarded).
    check("full_head", id_bus.id_pc_o, 32'h10);
    branch = 1'b1;  branch_pc = 32'h40;
    tick();
    branch = 1'b0;
    check("br_empty", {31'b0, id_bus.id_valid_o}, 32'h0);
    check("br_addr", rom_addr, 32'h40);
    expect_pc(32'h40); expect_pc(32'h44);
    id_bus.id_ready_i = 1'b1;
    tick();
    check("br_head_valid", {31'b0, id_bus.id_valid_o}, 32'h1);
    check("br_head_pc", id_bus.id_pc_o, 32'h40);
    check("br_head_inst", id_bus.id_inst_o, rom_word(32'h40));
    tick();
    tick();
    id_bus.id_ready_i = 1'b0;
    check("p3_drained", exp_q.size(), 32'd0);

    // Flush and branch together: flush target wins.
    flush = 1'b1;  flush_pc = 32'h20;
    branch = 1'b1; branch_pc = 32'h80;
    tick();
    flush = 1'b0;
    check("prio_addr", rom_addr, 32'h20);
    check("prio_empty", {31'b0, id_bus.id_valid_o}, 32'h0);
    // Misaligned branch target is word-aligned.
    branch = 1'b1; branch_pc = 32'h43;
    tick();
    branch = 1'b0;
    check("align_addr", rom_addr, 32'h40);
    check("align_empty", {31'b0, id_bus.id_valid_o}, 32'h0);
    expect_pc(32'h40); expect_pc(32'h44);
    id_bus.id_ready_i = 1'b1;
    tick();
    tick();
    tick();

    // Flush with a concurrent pop of head 0x48, then wrap past 2^32.
    expect_pc(32'h48);
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0);
    flush = 1'b1;  flush_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    check("wrap_empty", {31'b0, id_bus.id_valid_o}, 32'h0);
    check("wrap_addr", rom_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    tick();
    id_bus.id_ready_i = 1'b0;
    check("p5_drained", exp_q.size(), 32'd0);

    // Reset mid-stream with a full queue and a concurrent branch.
    tick();
    check("pre_rst_full", {31'b0, id_bus.id_valid_o}, 32'h1);
    check("pre_rst_addr", rom_addr, 32'hC);
    branch = 1'b1; branch_pc = 32'h100;
    do_reset();
    branch = 1'b0;
    tick();
    tick();
    check("final_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Instruction-fetch stage that sits directly upstream of the instruction ROM and directly upstream of the decode stage. It owns the program counter and drives the ROM's chip-enable and byte address. It captures the ROM's combinational instruction word into a small FIFO of {pc, inst} entries and presents the FIFO head to decode under a valid/ready handshake. Pipeline flush and branch redirect discard all queued entries and reload the PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded by reset; bits [1:0] must be 0.
QDEPTH, 2, FIFO entries; power of two, 2..8.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
rom_ce_o  output  1  ROM chip enable; ROM returns 0 when this is low.
rom_addr_o  output  32  ROM byte address, always equal to the current PC.
rom_inst_i  input  32  ROM instruction word; combinational from rom_addr_o, valid in the same cycle.
id_valid_o  output  1  FIFO head is valid.
id_ready_i  input  1  decode accepts the head this cycle.
id_pc_o  output  32  PC of the head entry.
id_inst_o  output  32  instruction of the head entry.
flush_i  input  1  pipeline flush (exception).
flush_pc_i  input  32  target PC for a flush.
branch_i  input  1  branch taken, redirect fetch.
branch_pc_i  input  32  target PC for a branch.

Behaviour:
- Reset: the cycle in which rst is high is the reset cycle. On the clock edge that ends it:
  - pc <= RESET_PC; rom_ce_o <= 0.
  - FIFO becomes empty; id_valid_o = 0.
  - id_pc_o = 0 and id_inst_o = 0.
- rom_ce_o: registered. It is 0 during reset and becomes 1 on the first clock edge with rst low. No fetch occurs while rom_ce_o = 0.
- rom_addr_o: equals pc at all times, including while rom_ce_o = 0.
- Pop: a pop occurs when id_valid_o && id_ready_i. id_ready_i has no effect while id_valid_o = 0.
- Fetch: a fetch occurs when rom_ce_o && no redirect && (count < QDEPTH || pop).
  - On a fetch, {pc, rom_inst_i} is pushed at the tail and pc <= pc + 4.
  - pc wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- No fetch: pc holds its value.
- Simultaneous push and pop when full: allowed; count stays at QDEPTH.
- Latency: an instruction fetched in cycle N is visible on id_* in cycle N+1 at the earliest (registered FIFO storage). Sustained throughput is one instruction per cycle while decode is ready.
- Output when empty: id_valid_o = 0 and id_pc_o = id_inst_o = 0 (NOP); stale entries are never exposed.
- Head ordering: id_* always reflect the oldest entry. The head is stable while id_valid_o && !id_ready_i.
- Redirect: redirect = flush_i || branch_i.
  - Target: flush_pc_i if flush_i, otherwise branch_pc_i. flush_i has priority when both are asserted.
  - On the edge: FIFO is emptied, no push occurs, pc <= {target[31:2], 2'b00}.
  - A pop in the same cycle still counts as accepted by decode; the FIFO is cleared regardless.
  - Next cycle: id_valid_o = 0, and the fetch from the target begins.
- Redirect while rom_ce_o = 0: pc is still loaded with the target.
- Reset priority: rst overrides redirect and fetch in the same cycle, including reset in the middle of a stall with a full FIFO.
- Counter width: count is clog2(QDEPTH)+1 bits. Read and write pointers wrap modulo QDEPTH.

Test Plan:
- Reset release, RESET_PC=0, id_ready_i=1, ROM preloaded: rom_ce_o rises 1 cycle after rst falls; id_pc_o sequence is 0,4,8,... one per cycle, paired with mem[0],mem[1],...
- Backpressure: id_ready_i=0 for 5 cycles. Required: FIFO fills to 2, pc holds at 8, head stays pc=0. Release id_ready_i: pcs 0,4,8,C appear consecutively with no gap or duplicate.
- Branch with branch_pc_i=32'h40 while FIFO is full: next cycle id_valid_o=0; following cycle id_pc_o=0x40 with mem[16]. No old entry is ever output.
- Simultaneous flush_i (flush_pc_i=0x20) and branch_i (branch_pc_i=0x80): pc becomes 0x20. Also branch_pc_i=0x43: pc becomes 0x40.
- Wrap: flush to 32'hFFFF_FFFC with id_ready_i=1: id_pc_o sequence is FFFFFFFC then 00000000.
- Reset asserted mid-stream with a full FIFO and a concurrent branch_i: after the edge, id_valid_o=0, rom_ce_o=0, pc=RESET_PC, id_inst_o=0.
